// File: rtl/ice40_mac16_pipe.sv
// Pipelined multiply-accumulate over valid/first/last framed bursts, saturating or truncating output.
// Latency: Last beat registered at edge t gives OutValid after edge t+MUL_STAGES+1.
// Backpressure: none; ClkEn=0 freezes every register, including OutValid.
module ice40_mac16_pipe #(
    parameter int A_W        = 16,
    parameter int B_W        = 16,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 32,
    parameter int MUL_STAGES = 2,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 1
) (
    input  logic             Clock,
    input  logic             Aclr_n,
    input  logic             ClkEn,
    input  logic             InValid,
    input  logic             InFirst,
    input  logic             InLast,
    input  logic [A_W-1:0]   DataA,
    input  logic [B_W-1:0]   DataB,
    output logic             OutValid,
    output logic [OUT_W-1:0] Result,
    output logic             Overflow
);
    localparam int   P_W = A_W + B_W;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);

    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [2:0]       in_flg_q;
    logic [P_W-1:0]   a_ext, b_ext, prod_c;
    logic [P_W-1:0]   prod_q [MUL_STAGES];
    logic [2:0]       flg_q  [MUL_STAGES];
    logic [P_W-1:0]   p;
    logic             p_vld, p_fst, p_lst;
    logic [ACC_W-1:0] acc_q, acc_n, prod_ext, hi_s, hi_u;
    logic [ACC_W:0]   sum;
    logic             sticky_q, sticky_n, add_ovf, fits;
    logic [OUT_W-1:0] sat_val, res_n;

    // Operand input registers, matching the DSP block's input register stage.
    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            a_q      <= '0;
            b_q      <= '0;
            in_flg_q <= '0;
        end else if (ClkEn) begin
            a_q      <= DataA;
            b_q      <= DataB;
            in_flg_q <= {InValid, InFirst, InLast};
        end
    end

    // Extending to the full product width keeps the low P_W bits exact for both modes.
    assign a_ext  = {{B_W{SGN & a_q[A_W-1]}}, a_q};
    assign b_ext  = {{A_W{SGN & b_q[B_W-1]}}, b_q};
    assign prod_c = a_ext * b_ext;

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
                flg_q[i]  <= '0;
            end
        end else if (ClkEn) begin
            prod_q[0] <= prod_c;
            flg_q[0]  <= in_flg_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                flg_q[i]  <= flg_q[i-1];
            end
        end
    end

    assign p                   = prod_q[MUL_STAGES-1];
    assign {p_vld, p_fst, p_lst} = flg_q[MUL_STAGES-1];

    always_comb begin
        prod_ext          = {ACC_W{SGN & p[P_W-1]}};
        prod_ext[P_W-1:0] = p;
        sum               = {1'b0, acc_q} + {1'b0, prod_ext};
        if (SGN)
            add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        else
            add_ovf = sum[ACC_W];
        acc_n    = p_fst ? prod_ext : sum[ACC_W-1:0];
        sticky_n = p_fst ? 1'b0 : (sticky_q | add_ovf);
        // Value fits OUT_W when the bits above the output range are pure sign (or zero) extension.
        hi_s     = $signed(acc_n) >>> (OUT_W - 1);
        hi_u     = acc_n >> OUT_W;
        fits     = SGN ? ((&hi_s) | ~(|hi_s)) : ~(|hi_u);
        if (!SGN)
            sat_val = '1;
        else if (acc_n[ACC_W-1])
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        res_n = (SAT && !fits) ? sat_val : acc_n[OUT_W-1:0];
    end

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            OutValid <= 1'b0;
            Result   <= '0;
            Overflow <= 1'b0;
        end else if (ClkEn) begin
            OutValid <= p_vld & p_lst;
            if (p_vld) begin
                acc_q    <= acc_n;
                sticky_q <= sticky_n;
            end
            if (p_vld && p_lst) begin
                Result   <= res_n;
                Overflow <= sticky_n | ~fits;
            end
        end
    end
endmodule

// File: tb/tb_ice40_mac16_pipe.sv
// Directed bench: a default saturating instance, a truncating one, and two unsigned depth variants.
module tb_ice40_mac16_pipe;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clken, vld, fst, lst;
    logic [15:0] a, b;
    logic        ov  [4];
    logic [31:0] res [4];
    logic        of  [4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    ice40_mac16_pipe u_sat (
        .Clock(clk), .Aclr_n(rst_n), .ClkEn(clken), .InValid(vld), .InFirst(fst), .InLast(lst),
        .DataA(a), .DataB(b), .OutValid(ov[0]), .Result(res[0]), .Overflow(of[0]));
    ice40_mac16_pipe #(.SATURATE(0)) u_trunc (
        .Clock(clk), .Aclr_n(rst_n), .ClkEn(clken), .InValid(vld), .InFirst(fst), .InLast(lst),
        .DataA(a), .DataB(b), .OutValid(ov[1]), .Result(res[1]), .Overflow(of[1]));
    ice40_mac16_pipe #(.SIGNED(0), .SATURATE(0), .MUL_STAGES(1)) u_u1 (
        .Clock(clk), .Aclr_n(rst_n), .ClkEn(clken), .InValid(vld), .InFirst(fst), .InLast(lst),
        .DataA(a), .DataB(b), .OutValid(ov[2]), .Result(res[2]), .Overflow(of[2]));
    ice40_mac16_pipe #(.SIGNED(0), .SATURATE(0), .MUL_STAGES(3)) u_u3 (
        .Clock(clk), .Aclr_n(rst_n), .ClkEn(clken), .InValid(vld), .InFirst(fst), .InLast(lst),
        .DataA(a), .DataB(b), .OutValid(ov[3]), .Result(res[3]), .Overflow(of[3]));

    typedef struct {
        logic [15:0] a, b;
        logic        v, f, l;
        logic        ev;
        logic [31:0] er;
        logic        eo;
        logic [31:0] etr;
        logic        eto;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic [15:0] va, input logic [15:0] vb, input logic v, input logic f,
                       input logic l, input logic ev, input logic [31:0] er, input logic eo,
                       input logic [31:0] etr, input logic eto);
        vec_t e;
        e.a = va; e.b = vb; e.v = v; e.f = f; e.l = l;
        e.ev = ev; e.er = er; e.eo = eo; e.etr = etr; e.eto = eto;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [15:0] va, input logic [15:0] vb, input logic f, input logic l);
        a = va; b = vb; vld = 1'b1; fst = f; lst = l;
        @(posedge clk); #1;
        vld = 1'b0; fst = 1'b0; lst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_main(input string name);
        int got;
        got = 0;
        for (int n = 0; n < 10 && got == 0; n++) begin
            @(posedge clk); #1;
            if (ov[0]) got = 1;
        end
        chk(name, got, 32'd1);
    endtask

    initial begin
        int t0, got, held;
        int lat [4];
        logic [31:0] cr [4];
        logic        co [4];

        rst_n = 1'b1; clken = 1'b1; vld = 1'b0; fst = 1'b0; lst = 1'b0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_valid%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("reset_result%0d", k), res[k], 32'd0);
            chk($sformatf("reset_ovf%0d", k), 32'(of[k]), 32'd0);
        end
        #1 rst_n = 1'b1;

        // Each row's expectation is the output after that row's edge (three-edge latency).
        add(16'hFFFD, 16'd7,   1, 1, 1, 0, 32'd0,        0, 32'd0,        0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd0,        0, 32'd0,        0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd0,        0, 32'd0,        0);
        add(16'd1,    16'd100, 1, 1, 0, 1, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'd2,    16'd100, 1, 0, 0, 0, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'd3,    16'd100, 1, 0, 0, 0, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'd4,    16'd100, 1, 0, 1, 0, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'd5,    16'd5,   1, 1, 0, 0, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'd6,    16'd6,   1, 0, 1, 0, 32'hFFFFFFEB, 0, 32'hFFFFFFEB, 0);
        add(16'h8000, 16'h8000, 1, 1, 0, 1, 32'd1000,    0, 32'd1000,     0);
        add(16'h8000, 16'h8000, 1, 0, 0, 0, 32'd1000,    0, 32'd1000,     0);
        add(16'h8000, 16'h8000, 1, 0, 1, 1, 32'd61,      0, 32'd61,       0);
        add(16'd2,    16'd2,   1, 1, 1, 0, 32'd61,       0, 32'd61,       0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd61,       0, 32'd61,       0);
        add(16'd0,    16'd0,   0, 0, 0, 1, 32'h7FFFFFFF, 1, 32'hC0000000, 1);
        add(16'd0,    16'd0,   0, 0, 0, 1, 32'd4,        0, 32'd4,        0);
        add(16'd10,   16'd10,  1, 0, 1, 0, 32'd4,        0, 32'd4,        0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd4,        0, 32'd4,        0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd4,        0, 32'd4,        0);
        add(16'd0,    16'd0,   0, 0, 0, 1, 32'd104,      0, 32'd104,      0);
        add(16'd0,    16'd0,   0, 0, 0, 0, 32'd104,      0, 32'd104,      0);

        foreach (vq[i]) begin
            a = vq[i].a; b = vq[i].b; vld = vq[i].v; fst = vq[i].f; lst = vq[i].l;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i),     32'(ov[0]), 32'(vq[i].ev));
            chk($sformatf("vec%0d_result", i),    res[0],     vq[i].er);
            chk($sformatf("vec%0d_ovf", i),       32'(of[0]), 32'(vq[i].eo));
            chk($sformatf("vec%0d_tr_valid", i),  32'(ov[1]), 32'(vq[i].ev));
            chk($sformatf("vec%0d_tr_result", i), res[1],     vq[i].etr);
            chk($sformatf("vec%0d_tr_ovf", i),    32'(of[1]), 32'(vq[i].eto));
        end
        vld = 1'b0; fst = 1'b0; lst = 1'b0;
        idle(4);

        // Stall mid-burst, then stall while the result is presented.
        beat(16'd1, 16'd100, 1, 0);
        t0 = cyc;
        beat(16'd2, 16'd100, 0, 0);
        clken = 1'b0;
        idle(5);
        clken = 1'b1;
        beat(16'd3, 16'd100, 0, 0);
        beat(16'd4, 16'd100, 0, 1);
        wait_main("stall_seen");
        chk("stall_latency", cyc - t0, 32'd11);
        chk("stall_result", res[0], 32'd1000);
        clken = 1'b0;
        held = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!ov[0] || res[0] !== 32'd1000) held = 0;
        end
        chk("stall_hold", held, 32'd1);
        clken = 1'b1;
        idle(1);
        chk("valid_one_cycle", 32'(ov[0]), 32'd0);
        chk("result_held", res[0], 32'd1000);
        idle(4);

        // Unsigned full-scale product and latency per pipeline depth.
        beat(16'hFFFF, 16'hFFFF, 1, 1);
        for (int k = 0; k < 4; k++) begin lat[k] = -1; cr[k] = '0; co[k] = 1'b0; end
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                if (ov[k] && lat[k] < 0) begin lat[k] = n; cr[k] = res[k]; co[k] = of[k]; end
        end
        chk("lat_ms2", lat[0], 32'd3);
        chk("signed_m1sq", cr[0], 32'd1);
        chk("lat_ms1", lat[2], 32'd2);
        chk("u1_result", cr[2], 32'hFFFE0001);
        chk("u1_ovf", 32'(co[2]), 32'd0);
        chk("lat_ms3", lat[3], 32'd4);
        chk("u3_result", cr[3], 32'hFFFE0001);
        chk("u3_ovf", 32'(co[3]), 32'd0);

        // 1024 beats of 2^30 wrap the 40-bit accumulator back to zero; sticky flag must survive.
        for (int i = 0; i < 1024; i++) beat(16'h8000, 16'h8000, i == 0, 0);
        beat(16'd2, 16'd2, 0, 1);
        wait_main("sticky_seen");
        chk("sticky_result", res[0], 32'd4);
        chk("sticky_ovf", 32'(of[0]), 32'd1);
        chk("sticky_tr_result", res[1], 32'd4);
        chk("sticky_tr_ovf", 32'(of[1]), 32'd1);
        chk("sticky_u_result", res[2], 32'd4);
        chk("sticky_u_ovf", 32'(of[2]), 32'd1);
        idle(4);

        // Asynchronous reset between edges aborts the burst in flight.
        beat(16'd5, 16'd5, 1, 0);
        beat(16'd6, 16'd6, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov[0]), 32'd0);
        chk("arst_result", res[0], 32'd0);
        chk("arst_ovf", 32'(of[0]), 32'd0);
        #1 rst_n = 1'b1;
        got = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov[0]) got = 1;
        end
        chk("abort_no_valid", got, 32'd0);
        beat(16'd7, 16'd8, 1, 1);
        wait_main("post_reset_seen");
        chk("post_reset_result", res[0], 32'd56);
        chk("post_reset_ovf", 32'(of[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ice40_mac16_pipe.md
Name: ice40_mac16_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit built on the iCE40UP DSP (SB_MAC16-class) multiply path.
- Successor to the fixed 16x16 registered multiplier. Adds configurable operand, accumulator and output widths, selectable multiply pipeline depth, signed/unsigned mode, a burst valid/first/last framing handshake, and saturating output with an overflow flag.
- Used by the keyword-spotting datapath for dot products and convolution taps.

Parameters:
- A_W, 16, DataA width (1..16).
- B_W, 16, DataB width (1..16).
- ACC_W, 40, accumulator width (>= A_W+B_W, <= 48).
- OUT_W, 32, Result width (<= ACC_W).
- MUL_STAGES, 2, product pipeline registers (1..3).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp Result to the OUT_W range, 0 = truncate (keep low OUT_W bits).

Ports:
- Clock  in  1  rising-edge clock.
- Aclr_n  in  1  asynchronous active-low reset.
- ClkEn  in  1  global clock enable; 0 freezes every register.
- InValid  in  1  operand beat valid.
- InFirst  in  1  first beat of a burst; qualified by InValid.
- InLast  in  1  last beat of a burst; qualified by InValid.
- DataA  in  A_W  operand A.
- DataB  in  B_W  operand B.
- OutValid  out  1  Result/Overflow valid; one ClkEn-qualified cycle.
- Result  out  OUT_W  accumulated burst sum.
- Overflow  out  1  the burst overflowed the accumulator or output range.

Behaviour:
- Reset (Aclr_n=0, async): all pipeline data and flag registers, the accumulator, OutValid, Result and Overflow go to 0. Effective immediately and independent of ClkEn.
- All registers update only on Clock edges where ClkEn=1. With ClkEn=0, all state, including OutValid, holds. Consumers sample OutValid only on ClkEn=1 cycles.
- Product path:
  - Operands are sign- or zero-extended per SIGNED; the product is A_W+B_W bits.
  - The product passes through MUL_STAGES registers.
  - InValid, InFirst and InLast travel in a matched shift pipe.
- Accumulate stage (one register), on a valid product:
  - First=1: acc = ext(prod), and the sticky overflow bit is cleared.
  - First=0: acc = acc + ext(prod).
  - Invalid beats leave acc unchanged.
- Accumulator overflow: if the signed (or unsigned) addition overflows ACC_W, acc wraps and the sticky bit is set.
- Beats without a preceding First accumulate onto the existing acc. This is legal and gives no error.
- Output stage, on a valid beat with Last=1, on the same edge as the final accumulate:
  - The new acc value is reduced to OUT_W.
  - SATURATE=1, signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SATURATE=1, unsigned: clamp to [0, 2^OUT_W-1].
  - SATURATE=0: truncate to the low OUT_W bits.
  - Overflow = sticky | (the new sum overflowed) | (the value did not fit OUT_W).
  - OutValid=1 for exactly one ClkEn cycle.
- Result and Overflow hold until the next OutValid.
- Latency: a Last beat accepted at edge t produces OutValid after edge t+MUL_STAGES+1, counted in ClkEn=1 edges.
- Throughput: one beat per enabled cycle, no bubbles. Back-to-back bursts are allowed: the First of burst N+1 may immediately follow the Last of burst N.
- First=1 and Last=1 on the same beat: Result = the single product, range-reduced.
- Reset mid-burst discards the partial sum. No OutValid is produced for that burst.

Test Plan (A_W=B_W=16, ACC_W=40, OUT_W=32, MUL_STAGES=2 unless stated):
1. Single beat, First=Last=1, A=-3, B=7, SIGNED=1 -> OutValid 3 enabled cycles later, Result=0xFFFFFFEB, Overflow=0.
2. Burst of 4 beats, A={1,2,3,4}, B=100, first/last framed -> one OutValid, Result=1000. Immediately follow with a 2-beat burst of 5*5, 6*6 -> Result=61 on the next OutValid, no gap.
3. Saturation: 3 beats of A=B=-32768 (each product 2^30) -> SATURATE=1: Result=0x7FFFFFFF, Overflow=1. SATURATE=0: Result=0xC0000000, Overflow=1. Next clean burst 2*2 -> Overflow=0.
4. Stall: ClkEn=0 for 5 cycles mid-burst and again while OutValid=1 -> Result unchanged versus the no-stall run, OutValid held through the stall, latency extended by 5.
5. Reset: Aclr_n pulsed low asynchronously (between edges) after 2 beats of a 4-beat burst -> OutValid, Result and Overflow go to 0 at once, no OutValid for the aborted burst. A new burst 7*8 -> Result=56.
6. SIGNED=0, SATURATE=0: A=0xFFFF, B=0xFFFF, single beat -> Result=0xFFFE0001, Overflow=0. Sweep MUL_STAGES=1 and 3 -> latency 2 and 4 respectively.
